// File: rtl/quesadilla_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the shared memory port.
interface quesadilla_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // IF stage requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  // MEM stage requester
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_stall;

  // Shared memory port
  logic              p_en;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [BE_W-1:0]   p_be;
  logic [DATA_W-1:0] p_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, p_rdata,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
    output p_en, p_we, p_addr, p_wdata, p_be
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, p_rdata,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
    input  p_en, p_we, p_addr, p_wdata, p_be
  );
endinterface

// File: rtl/quesadilla_mem_arbiter.sv
// Single-port memory arbiter: MEM-priority IF/MEM sharing with an IF starvation guard.
module quesadilla_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  quesadilla_mem_arbiter_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_SAT   = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [STV_W-1:0]  r_starve_cnt;
  logic              r_sel_if;
  logic              r_p_en;
  logic              r_p_we;
  logic [ADDR_W-1:0] r_p_addr;
  logic [DATA_W-1:0] r_p_wdata;
  logic [BE_W-1:0]   r_p_be;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_done;
  logic              w_if_wins;

  // IF wins only when MEM is absent or IF has waited through STARVE_MAX MEM grants
  assign w_if_wins = bus.if_req & (~bus.mem_req | (r_starve_cnt == STV_SAT));

  // Issue/wait/response sequencer; the latched p_* copy is the authoritative request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_sel_if     <= 1'b0;
      r_p_en       <= 1'b0;
      r_p_we       <= 1'b0;
      r_p_addr     <= '0;
      r_p_wdata    <= '0;
      r_p_be       <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_done    <= 1'b0;
      r_mem_done   <= 1'b0;
    end else begin
      r_p_en     <= 1'b0;
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!bus.if_req) r_starve_cnt <= '0;
          if (w_if_wins) begin
            r_sel_if     <= 1'b1;
            r_p_we       <= 1'b0;
            r_p_addr     <= bus.if_addr;
            r_p_wdata    <= '0;
            r_p_be       <= '1;
            r_starve_cnt <= '0;
            r_p_en       <= 1'b1;
            r_state      <= S_ISSUE;
          end else if (bus.mem_req) begin
            r_sel_if  <= 1'b0;
            r_p_we    <= bus.mem_we;
            r_p_addr  <= bus.mem_addr;
            r_p_wdata <= bus.mem_wdata;
            r_p_be    <= bus.mem_be;
            r_p_en    <= 1'b1;
            r_state   <= S_ISSUE;
            // MEM can only beat a waiting IF below saturation, so no clamp needed
            if (bus.if_req) r_starve_cnt <= r_starve_cnt + STV_W'(1);
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            if (!r_p_we) begin
              if (r_sel_if) r_if_rdata  <= bus.p_rdata;
              else          r_mem_rdata <= bus.p_rdata;
            end
            if (r_sel_if) r_if_done  <= 1'b1;
            else          r_mem_done <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered outputs; stalls are the only combinational paths
  assign bus.p_en      = r_p_en;
  assign bus.p_we      = r_p_we;
  assign bus.p_addr    = r_p_addr;
  assign bus.p_wdata   = r_p_wdata;
  assign bus.p_be      = r_p_be;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.mem_done  = r_mem_done;
  assign bus.if_stall  = bus.if_req & ~r_if_done;
  assign bus.mem_stall = bus.mem_req & ~r_mem_done;
endmodule

// File: tb/tb_quesadilla_mem_arbiter.sv
// Bench for quesadilla_mem_arbiter: transaction-level model plus directed scenarios.
module tb_quesadilla_mem_arbiter;
  localparam int unsigned LAT0   = 2;
  localparam int unsigned LAT1   = 1;
  localparam int unsigned STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quesadilla_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  quesadilla_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  quesadilla_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .STARVE_MAX(STARVE))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  quesadilla_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(STARVE))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C22_0004;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Fixed-latency memory for dut0: data valid only LAT0 cycles after a read strobe
  int          rd_cnt = 0;
  logic [31:0] rd_data = '0;
  always @(posedge clk) begin
    if (bus0.p_en && !bus0.p_we) begin
      rd_cnt  <= 1;
      rd_data <= mem_word(bus0.p_addr);
    end else if (rd_cnt != 0 && rd_cnt < int'(LAT0)) begin
      rd_cnt <= rd_cnt + 1;
    end else begin
      rd_cnt <= 0;
    end
  end
  assign bus0.p_rdata = (rd_cnt == int'(LAT0)) ? rd_data : (32'hBAD0_0000 ^ 32'(cyc));

  // dut1 mirrors dut0's requests; its memory answers immediately from the latched address
  assign bus1.if_req    = bus0.if_req;
  assign bus1.if_addr   = bus0.if_addr;
  assign bus1.mem_req   = bus0.mem_req;
  assign bus1.mem_we    = bus0.mem_we;
  assign bus1.mem_addr  = bus0.mem_addr;
  assign bus1.mem_wdata = bus0.mem_wdata;
  assign bus1.mem_be    = bus0.mem_be;
  assign bus1.p_rdata   = mem_word(bus1.p_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model for dut0: age counts cycles since the request was sampled
  int          age = -1;
  bit          win_if = 1'b0;
  int          starve = 0;
  logic        l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic [3:0]  l_be = '0;
  logic [31:0] e_if_rdata = '0, e_mem_rdata = '0;

  initial begin : model
    logic s_rst, s_ifr, s_memr, s_we, e_done;
    logic [31:0] s_ifa, s_ma, s_wd;
    logic [3:0]  s_be;
    forever begin
      @(posedge clk);
      s_rst = rst; s_ifr = bus0.if_req; s_memr = bus0.mem_req; s_we = bus0.mem_we;
      s_ifa = bus0.if_addr; s_ma = bus0.mem_addr; s_wd = bus0.mem_wdata; s_be = bus0.mem_be;
      if (s_rst) begin
        age = -1; starve = 0; e_if_rdata = '0; e_mem_rdata = '0;
        l_addr = '0; l_we = 1'b0; l_wdata = '0; l_be = '0;
      end else if (age < 0) begin
        if (!s_ifr) starve = 0;
        if (s_ifr || s_memr) begin
          win_if = s_ifr && (!s_memr || starve == int'(STARVE));
          if (win_if) begin
            l_addr = s_ifa; l_we = 1'b0; l_be = 4'hF; starve = 0;
          end else begin
            l_addr = s_ma; l_we = s_we; l_wdata = s_wd; l_be = s_be;
            if (s_ifr && starve < int'(STARVE)) starve++;
          end
          age = 1;
        end
      end else if (age == int'(LAT0) + 1) begin
        if (!l_we) begin
          if (win_if) e_if_rdata  = mem_word(l_addr);
          else        e_mem_rdata = mem_word(l_addr);
        end
        age++;
      end else if (age == int'(LAT0) + 2) begin
        age = -1;
      end else begin
        age++;
      end
      #1;
      e_done = (age == int'(LAT0) + 2);
      chk("p_en",      bus0.p_en,      age == 1);
      chk("p_we",      bus0.p_we,      l_we);
      chk("p_addr",    bus0.p_addr,    l_addr);
      chk("p_be",      bus0.p_be,      l_be);
      if (l_we) chk("p_wdata", bus0.p_wdata, l_wdata);
      chk("if_done",   bus0.if_done,   e_done && win_if);
      chk("mem_done",  bus0.mem_done,  e_done && !win_if);
      chk("if_rdata",  bus0.if_rdata,  e_if_rdata);
      chk("mem_rdata", bus0.mem_rdata, e_mem_rdata);
      chk("if_stall",  bus0.if_stall,  bus0.if_req && !(e_done && win_if));
      chk("mem_stall", bus0.mem_stall, bus0.mem_req && !(e_done && !win_if));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : directed
    int got[$];
    bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.mem_req = 1'b0; bus0.mem_we = 1'b0;
    bus0.mem_addr = '0; bus0.mem_wdata = '0; bus0.mem_be = '0;

    // Reset state
    step(3);
    chk("rst p_en", bus0.p_en, 1'b0);
    chk("rst p_addr", bus0.p_addr, 32'h0);
    chk("rst if_rdata", bus0.if_rdata, 32'h0);
    chk("rst mem_done", bus0.mem_done, 1'b0);
    chk("rst dut1 p_en", bus1.p_en, 1'b0);
    rst = 1'b0;
    step(2);

    // 1: single IF read
    @(negedge clk); bus0.if_req = 1'b1; bus0.if_addr = 32'h40; #1;
    chk("t1 stall t", bus0.if_stall, 1'b1);
    step(1);
    chk("t1 p_en", bus0.p_en, 1'b1);
    chk("t1 p_we", bus0.p_we, 1'b0);
    chk("t1 p_be", bus0.p_be, 4'hF);
    step(2);
    chk("t1 stall t+3", bus0.if_stall, 1'b1);
    step(1);
    chk("t1 if_done", bus0.if_done, 1'b1);
    chk("t1 if_rdata", bus0.if_rdata, 32'h8C22_0004);
    chk("t1 model rdata", e_if_rdata, 32'h8C22_0004);
    chk("t1 stall done", bus0.if_stall, 1'b0);
    bus0.if_req = 1'b0;
    step(3);

    // 2: simultaneous requests, MEM first then IF
    @(negedge clk); bus0.if_req = 1'b1; bus0.if_addr = 32'h44;
    bus0.mem_req = 1'b1; bus0.mem_we = 1'b0; bus0.mem_addr = 32'h100; #1;
    step(1);
    chk("t2 p_en mem", bus0.p_en, 1'b1);
    chk("t2 p_addr mem", bus0.p_addr, 32'h100);
    step(3);
    chk("t2 mem_done", bus0.mem_done, 1'b1);
    chk("t2 mem_rdata", bus0.mem_rdata, 32'h1257_6520);
    chk("t2 if_stall t+4", bus0.if_stall, 1'b1);
    bus0.mem_req = 1'b0;
    step(2);
    chk("t2 p_en if", bus0.p_en, 1'b1);
    chk("t2 p_addr if", bus0.p_addr, 32'h44);
    step(2);
    chk("t2 if_stall t+8", bus0.if_stall, 1'b1);
    step(1);
    chk("t2 if_done", bus0.if_done, 1'b1);
    chk("t2 if_rdata", bus0.if_rdata, 32'h1313_6464);
    bus0.if_req = 1'b0;
    step(3);

    // 3: MEM write leaves mem_rdata alone
    @(negedge clk); bus0.mem_req = 1'b1; bus0.mem_we = 1'b1; bus0.mem_addr = 32'h200;
    bus0.mem_wdata = 32'hDEAD_BEEF; bus0.mem_be = 4'b0011; #1;
    step(1);
    chk("t3 p_en", bus0.p_en, 1'b1);
    chk("t3 p_we", bus0.p_we, 1'b1);
    chk("t3 p_be", bus0.p_be, 4'b0011);
    chk("t3 p_wdata", bus0.p_wdata, 32'hDEAD_BEEF);
    step(1);
    chk("t3 p_en once", bus0.p_en, 1'b0);
    step(2);
    chk("t3 mem_done", bus0.mem_done, 1'b1);
    chk("t3 mem_rdata kept", bus0.mem_rdata, 32'h1257_6520);
    bus0.mem_req = 1'b0; bus0.mem_we = 1'b0; bus0.mem_be = '0;
    step(3);

    // 4: both held high: four MEM grants, then IF, then MEM again
    @(negedge clk); bus0.if_req = 1'b1; bus0.if_addr = 32'h48;
    bus0.mem_req = 1'b1; bus0.mem_addr = 32'h104; #1;
    for (int k = 1; k <= 29; k++) begin
      step(1);
      if (bus0.if_done && bus0.mem_done) chk("t4 double done", 1'b1, 1'b0);
      if (bus0.mem_done) got.push_back(0);
      if (bus0.if_done)  got.push_back(1);
    end
    bus0.if_req = 1'b0; bus0.mem_req = 1'b0;
    chk("t4 grant count", 64'(got.size()), 64'd6);
    for (int g = 0; g < 6; g++) begin
      if (g < got.size()) chk("t4 grant order", 64'(got[g]), (g == 4) ? 64'd1 : 64'd0);
      else chk("t4 grant missing", 64'(g), 64'hFFFF);
    end
    step(8);

    // 5: reset during WAIT abandons the read
    @(negedge clk); bus0.if_req = 1'b1; bus0.if_addr = 32'h4C; #1;
    step(1);
    chk("t5 p_en", bus0.p_en, 1'b1);
    step(1);
    rst = 1'b1; bus0.if_req = 1'b0;
    step(1);
    chk("t5 rst p_en", bus0.p_en, 1'b0);
    chk("t5 rst if_rdata", bus0.if_rdata, 32'h0);
    chk("t5 rst mem_rdata", bus0.mem_rdata, 32'h0);
    chk("t5 rst p_addr", bus0.p_addr, 32'h0);
    chk("t5 rst p_be", bus0.p_be, 4'h0);
    rst = 1'b0;
    step(1);
    chk("t5 no done", bus0.if_done, 1'b0);
    step(2);
    @(negedge clk); bus0.if_req = 1'b1; bus0.if_addr = 32'h80; #1;
    step(4);
    chk("t5 if_done", bus0.if_done, 1'b1);
    chk("t5 if_rdata", bus0.if_rdata, 32'h13D7_64A0);
    bus0.if_req = 1'b0;
    step(6);

    // 6: MEM_LAT=1 instance, single MEM read
    @(negedge clk); bus0.mem_req = 1'b1; bus0.mem_we = 1'b0; bus0.mem_addr = 32'h300; #1;
    step(1);
    chk("t6 p_en", bus1.p_en, 1'b1);
    step(1);
    chk("t6 p_en off", bus1.p_en, 1'b0);
    chk("t6 early done", bus1.mem_done, 1'b0);
    step(1);
    chk("t6 mem_done", bus1.mem_done, 1'b1);
    chk("t6 mem_rdata", bus1.mem_rdata, 32'h1057_6720);
    bus0.mem_req = 1'b0;
    step(1);
    chk("t6 idle p_en", bus1.p_en, 1'b0);
    chk("t6 idle done", bus1.mem_done, 1'b0);
    step(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/quesadilla_mem_arbiter.md
# quesadilla_mem_arbiter

Single-port memory arbiter for the quesadilla MIPS pipeline. Shares one fixed-latency, single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores). Sequences each access through an issue/wait/response FSM and produces per-requester stall signals for the hazard logic. MEM has priority, with a starvation guard for IF.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- MEM_LAT, 2, cycles from port issue to valid p_rdata (>=1)
- STARVE_MAX, 4, consecutive MEM grants allowed while IF waits

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF access request, read only
- if_addr  in  ADDR_W  IF address
- if_rdata  out  DATA_W  last IF read data
- if_done  out  1  one-cycle IF completion pulse
- if_stall  out  1  if_req & ~if_done
- mem_req  in  1  MEM access request
- mem_we  in  1  1 = write
- mem_addr  in  ADDR_W  MEM address
- mem_wdata  in  DATA_W  write data
- mem_be  in  DATA_W/8  write byte enables
- mem_rdata  out  DATA_W  last MEM read data
- mem_done  out  1  one-cycle MEM completion pulse
- mem_stall  out  1  mem_req & ~mem_done
- p_en  out  1  memory port access strobe, one cycle per transaction
- p_we  out  1  port write enable
- p_addr  out  ADDR_W  port address
- p_wdata  out  DATA_W  port write data
- p_be  out  DATA_W/8  port byte enables
- p_rdata  in  DATA_W  port read data, valid MEM_LAT cycles after p_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests. If none, stay. Otherwise pick the winner, latch its address, we, wdata, and be (IF: we=0, be=all ones), then go to ISSUE.
- Winner selection: MEM wins unless if_req is set and starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt increments on a MEM grant while if_req=1. It clears on any IF grant or when if_req=0 in IDLE, and saturates at STARVE_MAX.
- ISSUE: p_en=1, with p_we, p_addr, p_wdata, and p_be driven from the latched values. Go to WAIT.
- WAIT: runs for MEM_LAT cycles. In the last WAIT cycle, a read captures p_rdata into the winner's rdata register. Then go to RESP.
- RESP: the winner's done=1 for exactly one cycle. Then go to IDLE.
- Writes never update mem_rdata. IF reads update only if_rdata; MEM reads update only mem_rdata.
- Dropping req mid-transaction does not abort the access; done still pulses.
- Requesters hold addr/data stable from req until done. The latched copy is authoritative.
- Reset values: state=IDLE, p_en=0, p_we=0, p_addr=0, p_wdata=0, p_be=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0, starve_cnt=0.
- Reset mid-transaction: the access is abandoned, no done pulse is issued, p_en=0 from the cycle after rst is sampled, and p_rdata from the abandoned read is ignored.

## Timing
- Request sampled in IDLE at cycle t:
  - p_en at t+1
  - p_rdata capture at t+1+MEM_LAT
  - done at t+2+MEM_LAT
  - next IDLE sample at t+3+MEM_LAT
- Transaction period is MEM_LAT+3 cycles; only one access is outstanding at a time.
- A req still high in the IDLE cycle after done counts as a new request.
- if_stall and mem_stall are combinational; the stall drops in the done cycle.
- All port outputs and rdata/done outputs are registered; no combinational path from the req inputs to the p_* outputs.

## Test plan
1. Single IF read, MEM_LAT=2, if_addr=0x00000040, p_rdata=0x8C220004 at t+3 -> p_en=1, p_we=0, p_be=4'hF at t+1; if_done=1 at t+4 with if_rdata=0x8C220004; if_stall=1 for t..t+3.
2. if_req and mem_req (read 0x00000100) both rise at t -> MEM issued at t+1, mem_done at t+4; IF issued at t+6, if_done at t+9; if_stall=1 throughout t..t+8.
3. MEM write, addr 0x00000200, wdata 0xDEADBEEF, be 4'b0011 -> single p_en cycle at t+1 with p_we=1, p_be=4'b0011; mem_done at t+4; mem_rdata unchanged.
4. mem_req and if_req both held high continuously -> MEM granted 4 times, IF gets the 5th grant, then MEM resumes; no done pulse is ever missing or duplicated.
5. rst asserted during WAIT -> no done pulse, p_en=0 next cycle, all outputs at reset values; a following IF read completes in 4 cycles with the correct data.
6. MEM_LAT=1 build, single MEM read -> p_en at t+1, capture at t+2, mem_done at t+3, next IDLE at t+4.
